// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode, funct and ALU-control encodings for the ID/EX stage.
// Contents: main-decoder ALUOp codes, R-type funct codes, and the 4-bit
// {ainvert,binvert,alu_op} control words understood by the 32-bit ALU.
package mips_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALU-control decoder (main_op + funct -> ALU controls).
// Ports:
//   main_op [1:0]  in   main-decoder ALUOp (add / sub / R-type / reserved)
//   funct   [5:0]  in   R-type function field
//   ainvert        out  ALU A-invert control
//   binvert        out  ALU B-invert control
//   alu_op  [1:0]  out  ALU operation select
//   illegal        out  function not decodable; controls fall back to add
module alu_ctrl_decode
    import mips_pkg::*;
(
    input  logic [1:0] main_op,
    input  logic [5:0] funct,
    output logic       ainvert,
    output logic       binvert,
    output logic [1:0] alu_op,
    output logic       illegal
);

    logic [3:0] ctrl;

    always_comb begin
        ctrl    = CTRL_ADD;
        illegal = 1'b0;
        if (main_op == ALUOP_SUB) begin
            ctrl = CTRL_SUB;
        end else if (main_op == ALUOP_RTYPE) begin
            case (funct)
                FUNCT_ADD: ctrl = CTRL_ADD;
                FUNCT_SUB: ctrl = CTRL_SUB;
                FUNCT_AND: ctrl = CTRL_AND;
                FUNCT_OR:  ctrl = CTRL_OR;
                FUNCT_SLT: ctrl = CTRL_SLT;
                FUNCT_NOR: ctrl = CTRL_NOR;
                default:   illegal = 1'b1;
            endcase
        end else if (main_op != ALUOP_ADD) begin
            illegal = 1'b1;
        end
    end

    assign {ainvert, binvert, alu_op} = ctrl;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU-control decode and valid/ready handshake.
// Optional feature macro: ID_EX_FORWARD_EN (adds EX/MEM result forwarding at capture).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid / in_ready             upstream handshake (in_ready combinational)
//   flush                           kill held instruction; drops a same-cycle capture
//   rs_data, rt_data, imm           operands and sign-extended immediate
//   alu_src                         0: B = rt_data, 1: B = imm
//   main_op, funct                  ALU control source fields
//   rs_addr, rt_addr, dest_addr     register numbers
//   reg_write, mem_read, mem_write  control bits
//   fwd_valid, fwd_addr, fwd_data   EX/MEM forwarding source (ID_EX_FORWARD_EN only)
//   out_valid / out_ready           downstream handshake
//   a_out, b_out                    registered ALU operands
//   alu_op, ainvert, binvert        registered ALU controls
//   dest_out                        registered destination
//   reg_write_out, mem_read_out,
//   mem_write_out                   registered control, forced 0 when not valid
//   illegal                         held instruction has undecodable ALU function
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic [WIDTH-1:0]   rs_data,
    input  logic [WIDTH-1:0]   rt_data,
    input  logic [WIDTH-1:0]   imm,
    input  logic               alu_src,
    input  logic [1:0]         main_op,
    input  logic [5:0]         funct,
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [RADDR_W-1:0] rt_addr,
    input  logic [RADDR_W-1:0] dest_addr,
    input  logic               reg_write,
    input  logic               mem_read,
    input  logic               mem_write,
`ifdef ID_EX_FORWARD_EN
    input  logic               fwd_valid,
    input  logic [RADDR_W-1:0] fwd_addr,
    input  logic [WIDTH-1:0]   fwd_data,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic [1:0]         alu_op,
    output logic               ainvert,
    output logic               binvert,
    output logic [RADDR_W-1:0] dest_out,
    output logic               reg_write_out,
    output logic               mem_read_out,
    output logic               mem_write_out,
    output logic               illegal
);

    logic             capture;
    logic             load;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] rt_nxt;
    logic             d_ainvert;
    logic             d_binvert;
    logic [1:0]       d_alu_op;
    logic             d_illegal;
    logic             rw_q;
    logic             mr_q;
    logic             mw_q;

    alu_ctrl_decode u_dec (
        .main_op (main_op),
        .funct   (funct),
        .ainvert (d_ainvert),
        .binvert (d_binvert),
        .alu_op  (d_alu_op),
        .illegal (d_illegal)
    );

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;
    // A flushed capture is dropped entirely so the held outputs stay as they were.
    assign load     = capture && !flush;

`ifdef ID_EX_FORWARD_EN
    // Register 0 is hardwired zero and is never a forwarding target.
    assign a_nxt  = (fwd_valid && fwd_addr != '0 && fwd_addr == rs_addr) ? fwd_data : rs_data;
    assign rt_nxt = (fwd_valid && fwd_addr != '0 && fwd_addr == rt_addr) ? fwd_data : rt_data;
`else
    logic unused_addr;
    assign unused_addr = ^{rs_addr, rt_addr};
    assign a_nxt  = rs_data;
    assign rt_nxt = rt_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            alu_op    <= 2'b00;
            ainvert   <= 1'b0;
            binvert   <= 1'b0;
            dest_out  <= '0;
            rw_q      <= 1'b0;
            mr_q      <= 1'b0;
            mw_q      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= flush ? 1'b0 : capture ? 1'b1 : (out_valid && out_ready) ? 1'b0 : out_valid;
            if (load) begin
                a_out    <= a_nxt;
                b_out    <= alu_src ? imm : rt_nxt;
                alu_op   <= d_alu_op;
                ainvert  <= d_ainvert;
                binvert  <= d_binvert;
                dest_out <= dest_addr;
                // An undecodable instruction must not change architectural state.
                rw_q     <= reg_write && !d_illegal;
                mr_q     <= mem_read && !d_illegal;
                mw_q     <= mem_write && !d_illegal;
                illegal  <= d_illegal;
            end
        end
    end

    assign reg_write_out = out_valid && rw_q;
    assign mem_read_out  = out_valid && mr_q;
    assign mem_write_out = out_valid && mw_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage (table vectors + scoreboard + corner sequences).
module tb_id_ex_stage;

    localparam int W = 32;
    localparam int R = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         flush = 1'b0;
    logic [W-1:0] rs_data = '0;
    logic [W-1:0] rt_data = '0;
    logic [W-1:0] imm = '0;
    logic         alu_src = 1'b0;
    logic [1:0]   main_op = '0;
    logic [5:0]   funct = '0;
    logic [R-1:0] rs_addr = '0;
    logic [R-1:0] rt_addr = '0;
    logic [R-1:0] dest_addr = '0;
    logic         reg_write = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic [1:0]   alu_op;
    logic         ainvert;
    logic         binvert;
    logic [R-1:0] dest_out;
    logic         reg_write_out;
    logic         mem_read_out;
    logic         mem_write_out;
    logic         illegal;
`ifdef ID_EX_FORWARD_EN
    logic         fwd_valid = 1'b0;
    logic [R-1:0] fwd_addr = '0;
    logic [W-1:0] fwd_data = '0;
`endif

    id_ex_stage #(.WIDTH(W), .RADDR_W(R)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .imm           (imm),
        .alu_src       (alu_src),
        .main_op       (main_op),
        .funct         (funct),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .dest_addr     (dest_addr),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
`ifdef ID_EX_FORWARD_EN
        .fwd_valid     (fwd_valid),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .a_out         (a_out),
        .b_out         (b_out),
        .alu_op        (alu_op),
        .ainvert       (ainvert),
        .binvert       (binvert),
        .dest_out      (dest_out),
        .reg_write_out (reg_write_out),
        .mem_read_out  (mem_read_out),
        .mem_write_out (mem_write_out),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   main_op;
        logic [5:0]   funct;
        logic         src;
        logic [W-1:0] rs, rt, imm;
        logic [R-1:0] ra, rb, dest;
        logic         rw, mr, mw;
        logic [W-1:0] ea, eb;
        logic [3:0]   ectrl;
        logic         eill, erw, emr, emw;
    } vec_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic [3:0]   ctrl;
        logic         ill, rw, mr, mw;
        logic [R-1:0] dest;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] mo, input logic [5:0] fn, input logic src,
                                input logic [W-1:0] rs, input logic [W-1:0] rt, input logic [W-1:0] im,
                                input logic [R-1:0] dest, input logic rw, input logic mr, input logic mw,
                                input logic [W-1:0] ea, input logic [W-1:0] eb, input logic [3:0] ec,
                                input logic ei, input logic erw, input logic emr, input logic emw);
        vec_t v;
        v.main_op = mo; v.funct = fn; v.src = src; v.rs = rs; v.rt = rt; v.imm = im;
        v.ra = 5'd1; v.rb = 5'd2; v.dest = dest; v.rw = rw; v.mr = mr; v.mw = mw;
        v.ea = ea; v.eb = eb; v.ectrl = ec; v.eill = ei; v.erw = erw; v.emr = emr; v.emw = emw;
        return v;
    endfunction

    function automatic exp_t ex(input vec_t v);
        exp_t e;
        e.a = v.ea; e.b = v.eb; e.ctrl = v.ectrl; e.ill = v.eill;
        e.rw = v.erw; e.mr = v.emr; e.mw = v.emw; e.dest = v.dest;
        return e;
    endfunction

    task automatic drive(input vec_t v);
        main_op = v.main_op; funct = v.funct; alu_src = v.src;
        rs_data = v.rs; rt_data = v.rt; imm = v.imm;
        rs_addr = v.ra; rt_addr = v.rb; dest_addr = v.dest;
        reg_write = v.rw; mem_read = v.mr; mem_write = v.mw;
        in_valid = 1'b1;
    endtask

    // Present v until accepted (bounded), pushing its expectation at the accepting edge.
    task automatic send(input vec_t v, input bit rnd);
        bit done;
        done = 1'b0;
        drive(v);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(ex(v));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready never rose within 50 cycles");
        end
        in_valid = 1'b0;
    endtask

    // Compare each instruction as it is handed downstream; check qualification when idle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: unexpected output a=%h b=%h", a_out, b_out);
                end else begin
                    e = sb.pop_front();
                    chk("a_out", a_out, e.a);
                    chk("b_out", b_out, e.b);
                    chk("ctrl", {28'd0, ainvert, binvert, alu_op}, {28'd0, e.ctrl});
                    chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                    chk("dest_out", {27'd0, dest_out}, {27'd0, e.dest});
                    chk("ctl_out", {29'd0, reg_write_out, mem_read_out, mem_write_out},
                        {29'd0, e.rw, e.mr, e.mw});
                end
            end else if (!out_valid) begin
                chk("idle_ctl_zero", {29'd0, reg_write_out, mem_read_out, mem_write_out}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0]  = mk(2'b10, 6'h2A, 1'b0, 32'd5, 32'd9, 32'd0, 5'd3, 1, 0, 0, 32'd5, 32'd9, 4'b0111, 0, 1, 0, 0);
        tbl[1]  = mk(2'b00, 6'h00, 1'b1, 32'h100, 32'h77, 32'hFFFFFFFC, 5'd8, 1, 1, 0, 32'h100, 32'hFFFFFFFC, 4'b0010, 0, 1, 1, 0);
        tbl[2]  = mk(2'b00, 6'h15, 1'b1, 32'h200, 32'h55, 32'd8, 5'd0, 0, 0, 1, 32'h200, 32'd8, 4'b0010, 0, 0, 0, 1);
        tbl[3]  = mk(2'b01, 6'h3F, 1'b0, 32'd7, 32'd7, 32'd4, 5'd0, 0, 0, 0, 32'd7, 32'd7, 4'b0110, 0, 0, 0, 0);
        tbl[4]  = mk(2'b10, 6'h20, 1'b0, 32'h11, 32'h22, 32'd0, 5'd10, 1, 0, 0, 32'h11, 32'h22, 4'b0010, 0, 1, 0, 0);
        tbl[5]  = mk(2'b10, 6'h22, 1'b0, 32'h33, 32'h44, 32'd0, 5'd11, 1, 0, 0, 32'h33, 32'h44, 4'b0110, 0, 1, 0, 0);
        tbl[6]  = mk(2'b10, 6'h24, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 5'd12, 1, 0, 0, 32'hF0F0, 32'h0FF0, 4'b0000, 0, 1, 0, 0);
        tbl[7]  = mk(2'b10, 6'h25, 1'b0, 32'hA, 32'h5, 32'd0, 5'd13, 1, 0, 0, 32'hA, 32'h5, 4'b0001, 0, 1, 0, 0);
        tbl[8]  = mk(2'b10, 6'h27, 1'b0, 32'hDEAD, 32'hBEEF, 32'd0, 5'd14, 1, 0, 0, 32'hDEAD, 32'hBEEF, 4'b1100, 0, 1, 0, 0);
        tbl[9]  = mk(2'b10, 6'h00, 1'b0, 32'd1, 32'd2, 32'd0, 5'd15, 1, 0, 0, 32'd1, 32'd2, 4'b0010, 1, 0, 0, 0);
        tbl[10] = mk(2'b11, 6'h20, 1'b0, 32'd3, 32'd4, 32'd0, 5'd16, 1, 1, 1, 32'd3, 32'd4, 4'b0010, 1, 0, 0, 0);
        tbl[11] = mk(2'b10, 6'h20, 1'b1, 32'd6, 32'd7, 32'h123, 5'd17, 1, 0, 0, 32'd6, 32'h123, 4'b0010, 0, 1, 0, 0);

        // Reset held two cycles with a valid instruction present.
        drive(tbl[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_a_out", a_out, 32'd0);
        chk("rst_b_out", b_out, 32'd0);
        chk("rst_ctrl", {28'd0, ainvert, binvert, alu_op}, 32'd0);
        chk("rst_dest", {27'd0, dest_out}, 32'd0);
        chk("rst_ctl_out", {29'd0, reg_write_out, mem_read_out, mem_write_out}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        mon_en = 1'b1;

        // Table: back-to-back with steady ready, then with random back-pressure.
        for (int i = 0; i < 12; i++) send(tbl[i], i >= 6);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain_table", sb.size(), 32'd0);
        @(posedge clk);
        #1;

        // Stall: hold slt for 3 cycles while lw waits; raising ready accepts lw same cycle.
        out_ready = 1'b0;
        send(tbl[0], 1'b0);
        drive(tbl[1]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_a_out", a_out, 32'd5);
            chk("stall_b_out", b_out, 32'd9);
            chk("stall_ctrl", {28'd0, ainvert, binvert, alu_op}, 32'd7);
            chk("stall_rw", {31'd0, reg_write_out}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(tbl[1], 1'b0);
        @(negedge clk);
        chk("post_stall_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Flush of a stalled instruction with a new one offered.
        out_ready = 1'b0;
        send(tbl[4], 1'b0);
        drive(tbl[5]);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        void'(sb.pop_front());
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_rw_out", {31'd0, reg_write_out}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Flush beats capture even when the stage is ready.
        out_ready = 1'b1;
        drive(tbl[6]);
        flush = 1'b1;
        @(negedge clk);
        chk("flushcap_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flushcap_dropped", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

`ifdef ID_EX_FORWARD_EN
        v = mk(2'b10, 6'h20, 1'b0, 32'd1, 32'd2, 32'd0, 5'd9, 1, 0, 0, 32'hA5, 32'd2, 4'b0010, 0, 1, 0, 0);
        v.ra = 5'd3;
        fwd_valid = 1'b1; fwd_addr = 5'd3; fwd_data = 32'hA5;
        send(v, 1'b0);
        v = mk(2'b10, 6'h20, 1'b0, 32'd1, 32'd2, 32'd0, 5'd9, 1, 0, 0, 32'd1, 32'h5A, 4'b0010, 0, 1, 0, 0);
        v.rb = 5'd4;
        fwd_addr = 5'd4; fwd_data = 32'h5A;
        send(v, 1'b0);
        v = mk(2'b10, 6'h20, 1'b1, 32'd1, 32'd2, 32'h77, 5'd9, 1, 0, 0, 32'd1, 32'h77, 4'b0010, 0, 1, 0, 0);
        v.rb = 5'd4;
        send(v, 1'b0);
        v = mk(2'b10, 6'h20, 1'b0, 32'd1, 32'd2, 32'd0, 5'd9, 1, 0, 0, 32'd1, 32'd2, 4'b0010, 0, 1, 0, 0);
        v.ra = 5'd0;
        fwd_addr = 5'd0; fwd_data = 32'hA5;
        send(v, 1'b0);
        fwd_valid = 1'b0;
`else
        v = tbl[3];
        send(v, 1'b0);
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain_final", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
